// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush scheduler for the five-stage pipeline.
// Decides each cycle whether the D-stage instruction may advance, drives the
// PC/FD/DE/EM/MW register enables and clears, sequences the multiply/divide
// busy window and counts stall cycles for performance debug.
module hazard_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        freeze,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [1:0]  D_Tuse_rs,
  input  logic [1:0]  D_Tuse_rt,
  input  logic        D_is_md,
  input  logic [4:0]  E_A3,
  input  logic [1:0]  E_Tnew,
  input  logic [4:0]  M_A3,
  input  logic [1:0]  M_Tnew,
  input  logic        E_start,
  input  logic        E_md_div,
  output logic        PC_en,
  output logic        FD_en,
  output logic        DE_en,
  output logic        DE_reset,
  output logic        EM_en,
  output logic        EM_reset,
  output logic        MW_en,
  output logic        md_busy,
  output logic        stall,
  output logic [31:0] stall_cnt
);

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } md_state_e;

  localparam logic [CNT_W-1:0] MultLoad = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DivLoad  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CntOne   = {{(CNT_W-1){1'b0}}, 1'b1};

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             md_busy_q;
  logic [31:0]      stall_cnt_q;

  logic stall_e_rs, stall_m_rs, stall_e_rt, stall_m_rt;
  logic stall_data, stall_md, stall_int;

  // Data-hazard detection: a source stalls when a younger producer will not
  // have its result ready by the time D needs it. Tuse = 3 never compares
  // below a 2-bit Tnew, so unused sources drop out naturally.
  always_comb begin
    stall_e_rs = (D_rs != 5'd0) && (D_rs == E_A3) && (D_Tuse_rs < E_Tnew);
    stall_m_rs = (D_rs != 5'd0) && (D_rs == M_A3) && (D_Tuse_rs < M_Tnew);
    stall_e_rt = (D_rt != 5'd0) && (D_rt == E_A3) && (D_Tuse_rt < E_Tnew);
    stall_m_rt = (D_rt != 5'd0) && (D_rt == M_A3) && (D_Tuse_rt < M_Tnew);
    stall_data = stall_e_rs | stall_m_rs | stall_e_rt | stall_m_rt;
    // A start in E this cycle already blocks HI/LO users, before busy rises.
    stall_md   = D_is_md & (md_busy_q | E_start);
    stall_int  = (stall_data | stall_md) & ~freeze;
  end

  // Busy sequencer next state: load on an accepted start, otherwise count
  // down. The MDU runs on its own, so freeze does not hold the countdown.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (E_start && !freeze) begin
          cnt_d   = E_md_div ? DivLoad : MultLoad;
          state_d = (cnt_d != '0) ? StBusy : StIdle;
        end
      end
      StBusy: begin
        // Restarts while busy are ignored.
        cnt_d = cnt_q - CntOne;
        if (cnt_q == CntOne) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Busy sequencer state, counter and registered busy flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      md_busy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      md_busy_q <= (cnt_d != '0);
    end
  end

  // Stall-cycle counter, saturating rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
    end else if (stall_int && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  // Pipeline-register control decode: freeze beats stall beats normal flow.
  always_comb begin
    PC_en    = 1'b1;
    FD_en    = 1'b1;
    DE_en    = 1'b1;
    DE_reset = 1'b0;
    EM_en    = 1'b1;
    EM_reset = 1'b0;
    MW_en    = 1'b1;
    if (freeze) begin
      PC_en = 1'b0;
      FD_en = 1'b0;
      DE_en = 1'b0;
      EM_en = 1'b0;
      MW_en = 1'b0;
    end else if (stall_int) begin
      // Hold PC/FD, push a bubble into DE, let older stages drain.
      PC_en    = 1'b0;
      FD_en    = 1'b0;
      DE_reset = 1'b1;
    end
    // EM may not be on the global reset net, so clear it explicitly.
    if (reset) begin
      EM_reset = 1'b1;
    end
  end

  assign md_busy   = md_busy_q;
  assign stall     = stall_int;
  assign stall_cnt = stall_cnt_q;

endmodule
